imem_loader: RTL and testbench

- Upstream stage of risc_processor.
- Receives a program as a byte stream over a valid/ready link and assembles it into 32-bit instruction words.
- Writes each word into instruction memory through a write port, holding the processor in reset until the whole image is written.
- Then releases the processor (cpu_run) and reports completion.

---
 rtl/riscv_loader_pkg.sv | 21 ++
 rtl/imem_loader_byte_word_packer.sv | 47 ++++
 rtl/imem_loader.sv | 149 ++++++++++++++
 tb/tb_imem_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_loader_pkg.sv
// Shared definitions for the instruction-memory loader: widths, framing constants and FSM state codes.
package riscv_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned STATE_W        = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_HDR_HI = 3'd1;
  localparam state_t S_HDR_LO = 3'd2;
  localparam state_t S_WORD   = 3'd3;
  localparam state_t S_WRITE  = 3'd4;
  localparam state_t S_DONE   = 3'd5;
  localparam state_t S_ERR    = 3'd6;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// Big-endian 8->32 assembler: holds the first three bytes of a word and presents
// the complete word combinationally while its fourth byte is being accepted.
module byte_word_packer
  import riscv_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              byte_valid_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_next_c,
  output logic              word_valid_c
);

  localparam int unsigned HOLD_W   = WORD_W - BYTE_W;
  localparam int unsigned BCNT_W   = $clog2(BYTES_PER_WORD);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;

  assign word_next_c  = {hold_q, byte_i};
  assign word_valid_c = byte_valid_i && (cnt_q == LAST_BYTE);

  always_comb begin
    hold_d = hold_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      hold_d = '0;
      cnt_d  = '0;
    end else if (byte_valid_i) begin
      hold_d = {hold_q[HOLD_W-BYTE_W-1:0], byte_i};
      cnt_d  = word_valid_c ? '0 : cnt_q + BCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header and a big-endian byte stream,
// writes instruction memory word by word, then releases the processor.
module imem_loader
  import riscv_loader_pkg::*;
#(
  parameter int unsigned IMEM_AW    = 8,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [BYTE_W-1:0]  in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [WORD_W-1:0]  imem_wdata,
  output logic               cpu_run,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   words_loaded
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   index_q, index_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               we_q, we_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [IMEM_AW-1:0] addr_q;
  logic [WORD_W-1:0]  wdata_q;

  logic               xfer_c;
  logic               pk_clear_c;
  logic               word_valid_c;
  logic [WORD_W-1:0]  word_next_c;
  logic [CNT_W-1:0]   hdr_count_c;

  assign xfer_c      = in_valid && in_ready_q;
  assign hdr_count_c = {count_q[CNT_W-1:BYTE_W], in_data};

  byte_word_packer u_packer (
    .clk          (clk),
    .rst_n        (reset),
    .clear_i      (pk_clear_c),
    .byte_valid_i (xfer_c && (state_q == S_WORD)),
    .byte_i       (in_data),
    .word_next_c  (word_next_c),
    .word_valid_c (word_valid_c)
  );

  // Next state; handshake/strobe outputs decode the next state so they align with it.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    index_d    = index_q;
    words_d    = words_q;
    pk_clear_c = 1'b0;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_HDR_HI;
          words_d    = '0;
          pk_clear_c = 1'b1;
        end
      end
      S_HDR_HI: begin
        if (xfer_c) begin
          count_d = {in_data, count_q[BYTE_W-1:0]};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (xfer_c) begin
          count_d = hdr_count_c;
          if (hdr_count_c == '0) begin
            state_d = S_DONE;
          end else if (hdr_count_c > CNT_W'(IMEM_DEPTH)) begin
            state_d = S_ERR;
          end else begin
            state_d    = S_WORD;
            index_d    = '0;
            pk_clear_c = 1'b1;
          end
        end
      end
      S_WORD: begin
        if (word_valid_c) state_d = S_WRITE;
      end
      S_WRITE: begin
        index_d = index_q + CNT_W'(1);
        words_d = words_q + CNT_W'(1);
        state_d = (index_q + CNT_W'(1) == count_q) ? S_DONE : S_WORD;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) || (state_d == S_WORD);
    busy_d     = in_ready_d || (state_d == S_WRITE);
    we_d       = (state_d == S_WRITE);
    done_d     = (state_q == S_DONE);
    err_d      = (state_q == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      index_q    <= '0;
      words_q    <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      index_q    <= index_d;
      words_q    <= words_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      we_q       <= we_d;
      done_q     <= done_d;
      err_q      <= err_d;
      if (we_d) begin
        addr_q  <= index_q[IMEM_AW-1:0];
        wdata_q <= word_next_c;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign done         = done_q;
  assign cpu_run      = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: an image-level model predicts every memory write
// and the final status; a per-cycle monitor compares the DUT against it.
module tb_imem_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, imem_we, cpu_run, busy, done, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [15:0]   words_loaded;

  imem_loader #(.IMEM_AW(AW), .IMEM_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_run      (cpu_run),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        log_q[$];
  logic [7:0] img[$];
  int         errors = 0;
  int         checks = 0;
  logic       exp_done, exp_err;
  int         exp_words;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, got, want, $time);
    end
  endtask

  // Image model: header gives the count, each following 4 bytes form one big-endian word.
  task automatic build_model();
    int n;
    exp_q.delete();
    log_q.delete();
    n         = int'({img[0], img[1]});
    exp_err   = (n > DEPTH);
    exp_done  = !exp_err;
    exp_words = exp_err ? 0 : n;
    if (!exp_err) begin
      for (int i = 0; i < n; i++) begin
        int k;
        wr_t w;
        k   = 2 + 4 * i;
        w.a = 8'(i);
        w.d = {img[k], img[k+1], img[k+2], img[k+3]};
        exp_q.push_back(w);
      end
    end
  endtask

  // Per-cycle compare against the model while out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {24'h0, imem_addr}, 32'hFFFF_FFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", {24'h0, imem_addr}, {24'h0, e.a});
          chk("write_data", imem_wdata, e.d);
        end
        log_q.push_back({imem_addr, imem_wdata});
      end
      if (busy) chk("ready_vs_write", {31'h0, in_ready}, {31'h0, !imem_we});
      chk("cpu_run_eq_done", {31'h0, cpu_run}, {31'h0, done});
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Offers nbytes of img; with bubble set, in_valid drops every other cycle.
  task automatic send_img(input bit bubble, input int nbytes);
    int   idx = 0;
    int   cyc = 0;
    logic rdy;
    while (idx < nbytes && cyc < 4000) begin
      if (bubble && cyc[0]) begin
        in_valid = 1'b0;
        in_data  = 8'hFF;
      end else begin
        in_valid = 1'b1;
        in_data  = img[idx];
      end
      rdy = in_ready;
      @(posedge clk);
      if (in_valid && rdy) idx++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < nbytes) chk("send_timeout", 32'(idx), 32'(nbytes));
  endtask

  task automatic wait_end();
    int c = 0;
    while (!(done || err) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    if (!(done || err)) chk("wait_end_timeout", 32'(c), 32'd0);
  endtask

  task automatic check_final(input string tag);
    chk({tag, "_done"}, {31'h0, done}, {31'h0, exp_done});
    chk({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
    chk({tag, "_cpu_run"}, {31'h0, cpu_run}, {31'h0, exp_done});
    chk({tag, "_words"}, {16'h0, words_loaded}, 32'(exp_words));
    chk({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_log(input string nm, input int i, input logic [7:0] a, input logic [31:0] d);
    if (log_q.size() > i) begin
      chk({nm, "_addr"}, {24'h0, log_q[i].a}, {24'h0, a});
      chk({nm, "_data"}, log_q[i].d, d);
    end else begin
      chk({nm, "_missing"}, 32'(log_q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("reset_ready", {31'h0, in_ready}, 32'd0);
    chk("reset_busy", {31'h0, busy}, 32'd0);
    chk("reset_outs", {29'h0, done, err, cpu_run}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Two-word image with in_valid held high, plus latency to done.
    img = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00};
    build_model();
    pulse_start();
    lat = 0;
    fork
      send_img(1'b0, img.size());
      begin
        while (!done && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
      end
    join
    chk("latency_2w", 32'(lat), 32'd13);
    wait_end();
    check_final("two_word");
    chk("two_word_nwrites", 32'(log_q.size()), 32'd2);
    chk_log("two_word_w0", 0, 8'd0, 32'h2001_0005);
    chk_log("two_word_w1", 1, 8'd1, 32'hAC01_0000);
    chk("two_word_words_lit", {16'h0, words_loaded}, 32'd2);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("done_not_ready", {31'h0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;

    // Zero-length image.
    img = '{8'h00, 8'h00};
    build_model();
    pulse_start();
    send_img(1'b0, img.size());
    wait_end();
    check_final("zero");
    chk("zero_nwrites", 32'(log_q.size()), 32'd0);
    chk("zero_cpu_run_lit", {31'h0, cpu_run}, 32'd1);

    // Count 257 overflows the memory; then recover with a one-word image.
    img = '{8'h01, 8'h01};
    build_model();
    pulse_start();
    send_img(1'b0, img.size());
    wait_end();
    repeat (2) @(negedge clk);
    check_final("ovf");
    chk("ovf_err_lit", {31'h0, err}, 32'd1);
    chk("ovf_ready_lit", {31'h0, in_ready}, 32'd0);
    chk("ovf_cpu_run_lit", {31'h0, cpu_run}, 32'd0);
    img = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    build_model();
    pulse_start();
    send_img(1'b0, img.size());
    wait_end();
    check_final("ovf_recover");
    chk_log("ovf_recover_w0", 0, 8'd0, 32'hDEAD_BEEF);
    chk("ovf_recover_err_lit", {31'h0, err}, 32'd0);

    // One word with in_valid toggling every other cycle.
    img = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    build_model();
    pulse_start();
    send_img(1'b1, img.size());
    wait_end();
    check_final("bubble");
    chk("bubble_nwrites", 32'(log_q.size()), 32'd1);
    chk_log("bubble_w0", 0, 8'd0, 32'h1122_3344);

    // Reset after two bytes of the first word of a three-word image.
    img = '{8'h00, 8'h03, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3,
            8'hC0, 8'hC1, 8'hC2, 8'hC3};
    build_model();
    exp_q.delete();
    pulse_start();
    send_img(1'b0, 4);
    reset = 1'b0;
    #1;
    chk("rst_async_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_async_busy", {31'h0, busy}, 32'd0);
    chk("rst_async_flags", {28'h0, done, err, cpu_run, imem_we}, 32'd0);
    chk("rst_async_words", {16'h0, words_loaded}, 32'd0);
    chk("rst_async_bus", imem_wdata | {24'h0, imem_addr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    build_model();
    pulse_start();
    send_img(1'b0, img.size());
    wait_end();
    check_final("after_rst");
    chk_log("after_rst_w0", 0, 8'd0, 32'hA0A1_A2A3);
    chk_log("after_rst_w2", 2, 8'd2, 32'hC0C1_C2C3);

    // Restart from DONE; extra start pulses while loading are ignored.
    img = '{8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    build_model();
    pulse_start();
    chk("restart_cpu_run_hold", {31'h0, cpu_run}, 32'd1);
    chk("restart_busy", {31'h0, busy}, 32'd1);
    @(negedge clk);
    chk("restart_cpu_run_fall", {31'h0, cpu_run}, 32'd0);
    chk("restart_done_fall", {31'h0, done}, 32'd0);
    chk("restart_words_clr", {16'h0, words_loaded}, 32'd0);
    pulse_start();
    pulse_start();
    chk("restart_still_busy", {31'h0, busy}, 32'd1);
    send_img(1'b0, img.size());
    wait_end();
    check_final("restart");
    chk_log("restart_w0", 0, 8'd0, 32'hCAFE_BABE);

    // Full-depth image: 256 words, last address 255.
    img.delete();
    img.push_back(8'h01);
    img.push_back(8'h00);
    for (int k = 0; k < 4 * DEPTH; k++) img.push_back(8'(k * 7 + 3));
    build_model();
    pulse_start();
    send_img(1'b0, img.size());
    wait_end();
    check_final("full");
    chk("full_nwrites", 32'(log_q.size()), 32'd256);
    chk_log("full_last", 255, 8'd255, {8'(1020*7+3), 8'(1021*7+3), 8'(1022*7+3), 8'(1023*7+3)});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
